pipeline_hazard_scheduler: RTL

PIPELINE_HAZARD_SCHEDULER -- requirements
Module: pipeline_hazard_scheduler

---
 rtl/pipeline_hazard_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_scheduler.sv
// Hazard scheduler for a 5-stage in-order pipeline.
// Tracks the three instructions past decode (EX, MA, WB) and does three jobs:
// stalls decode for one cycle on a load-use hazard, flushes on a taken
// branch or jump, and drains the pipe after HLT before halting.
module pipeline_hazard_scheduler #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              de_valid,
    input  logic [REG_AW-1:0] de_rs1,
    input  logic [REG_AW-1:0] de_rs2,
    input  logic              de_need_rs1,
    input  logic              de_need_rs2,
    input  logic [REG_AW-1:0] de_rdst,
    input  logic              de_r_we,
    input  logic              de_is_load,
    input  logic              de_is_hlt,
    input  logic              ex_redirect,
    output logic              pc_en,
    output logic              ifde_en,
    output logic              ifde_flush,
    output logic              deex_bubble,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t            state_q, state_d;
    slot_t             ex_q, ma_q, wb_q, ex_d;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
    logic              load_use, issue, stall_ev, flush_ev;

    // Only the EX slot feeds hazard detection; older slots matter only for
    // occupancy while draining. The remaining fields are tracked for
    // completeness of the scoreboard and deliberately left unread.
    logic              unused_sb;
    assign unused_sb = ^{ma_q.rd, ma_q.we, ma_q.ld, wb_q};

    // Load-use: the instruction now in EX is a load whose result decode needs.
    // Everything else is covered by forwarding.
    always_comb begin
        load_use = de_valid && ex_q.valid && ex_q.we && ex_q.ld &&
                   ((de_need_rs1 && (ex_q.rd == de_rs1)) ||
                    (de_need_rs2 && (ex_q.rd == de_rs2)));
    end

    // Same-cycle pipeline control and next-state selection.
    always_comb begin
        pc_en       = 1'b1;
        ifde_en     = 1'b1;
        ifde_flush  = 1'b0;
        deex_bubble = 1'b0;
        issue       = 1'b0;
        stall_ev    = 1'b0;
        flush_ev    = 1'b0;
        state_d     = state_q;
        case (state_q)
            RUN: begin
                if (ex_redirect) begin
                    // Redirect wins; a hazard on the squashed instruction is moot.
                    ifde_flush  = 1'b1;
                    deex_bubble = 1'b1;
                    flush_ev    = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    ifde_en     = 1'b0;
                    deex_bubble = 1'b1;
                    stall_ev    = 1'b1;
                end else if (de_valid && de_is_hlt) begin
                    pc_en   = 1'b0;
                    ifde_en = 1'b0;
                    issue   = 1'b1;
                    state_d = DRAIN;
                end else begin
                    issue = de_valid;
                end
            end
            DRAIN: begin
                pc_en       = 1'b0;
                ifde_en     = 1'b0;
                deex_bubble = 1'b1;
                if (ex_redirect) begin
                    ifde_flush = 1'b1;
                    flush_ev   = 1'b1;
                end
                // EX refills with a bubble here, so after this edge the
                // scoreboard holds {bubble, ex_q, ma_q}: halt once that is empty.
                if (!ex_q.valid && !ma_q.valid) state_d = HALT;
            end
            HALT: begin
                pc_en       = 1'b0;
                ifde_en     = 1'b0;
                deex_bubble = 1'b1;
            end
            default: state_d = RUN;
        endcase
        // Reset must show the idle-run control values immediately.
        if (reset) begin
            pc_en       = 1'b1;
            ifde_en     = 1'b1;
            ifde_flush  = 1'b0;
            deex_bubble = 1'b0;
        end
    end

    // New EX slot contents and saturating counter next values.
    always_comb begin
        ex_d = '0;
        if (issue) ex_d = '{valid: 1'b1, rd: de_rdst, we: de_r_we, ld: de_is_load};
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_ev && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
        if (flush_ev && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
    end

    // State, scoreboard shift, halted flag and counters.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            ex_q     <= '0;
            ma_q     <= '0;
            wb_q     <= '0;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            ma_q     <= ex_q;
            wb_q     <= ma_q;
            halted_q <= (state_d == HALT);
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
